// File: rtl/dmem_responder.sv
// MEM-stage data-port responder: word RAM behind a fixed wait-state latency,
// one-cycle resp pulse and a combinational stall toward the pipeline.
module dmem_responder #(
  parameter int LATENCY    = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] rdata,
  output logic        resp,
  output logic        stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  logic [1:0]            state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] cap_addr_reg;
  logic [15:0]           cap_wdata_reg;
  logic [1:0]            cap_be_reg;
  logic                  cap_write_reg;

  logic                  req;
  logic [ADDR_WIDTH-1:0] idx_in;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_en;
  logic                  wr_en;
  logic                  unused_addr_bits;

  assign req    = read | write;
  assign idx_in = address[ADDR_WIDTH:1];
  assign unused_addr_bits = ^{address[15:ADDR_WIDTH+1], address[0]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_next = S_RESP;
          end else begin
            cnt_next   = CNT_LOAD;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With LATENCY == 1 RESP follows the accept edge directly, so the read
  // address must come from the live inputs rather than the capture register.
  assign rd_idx = (state_reg == S_IDLE) ? idx_in : cap_addr_reg;
  assign rd_en  = (state_next == S_RESP) && !reset &&
                  !((state_reg == S_IDLE) ? write : cap_write_reg);
  assign wr_en  = (state_reg == S_RESP) && cap_write_reg && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      cap_addr_reg  <= '0;
      cap_wdata_reg <= 16'h0000;
      cap_be_reg    <= 2'b00;
      cap_write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == S_IDLE && req) begin
        cap_addr_reg  <= idx_in;
        cap_wdata_reg <= wdata;
        cap_be_reg    <= mem_byte_enable;
        cap_write_reg <= write;
      end
    end
  end

  // One byte-wide RAM per lane keeps byte-enable writes simple to infer.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem [2**ADDR_WIDTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (wr_en && cap_be_reg[gi]) begin
          mem[cap_addr_reg] <= cap_wdata_reg[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          q_reg <= 8'h00;
        end else if (rd_en) begin
          q_reg <= mem[rd_idx];
        end
      end

      assign rdata[gi*8 +: 8] = q_reg;
    end
  endgenerate

  assign resp  = (state_reg == S_RESP);
  assign stall = req & ~resp;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=4 instance driven from a vector
// table plus hand sequences, and a LATENCY=1 instance for the short path.
module tb_dmem_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [2];
  logic        wr    [2];
  logic [15:0] addr  [2];
  logic [15:0] wd    [2];
  logic [1:0]  be    [2];
  logic [15:0] rdata [2];
  logic        resp  [2];
  logic        stall [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(4), .ADDR_WIDTH(10)) u_dut4 (
    .clk(clk), .reset(rst), .read(rd[0]), .write(wr[0]), .address(addr[0]),
    .wdata(wd[0]), .mem_byte_enable(be[0]), .rdata(rdata[0]), .resp(resp[0]),
    .stall(stall[0])
  );

  dmem_responder #(.LATENCY(1), .ADDR_WIDTH(10)) u_dut1 (
    .clk(clk), .reset(rst), .read(rd[1]), .write(wr[1]), .address(addr[1]),
    .wdata(wd[1]), .mem_byte_enable(be[1]), .rdata(rdata[1]), .resp(resp[1]),
    .stall(stall[1])
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge with the DUT idle; holds the request
  // until the resp edge, then drops it (a following call is back-to-back).
  task automatic txn(input int d, input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] wdv, input logic [1:0] b,
                     input logic [15:0] exp, input string nm);
    int lat = (d == 0) ? 4 : 1;
    rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = wdv; be[d] = b;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk({nm, " stall"}, 16'(stall[d]), 16'(c < lat));
      chk({nm, " resp"},  16'(resp[d]),  16'(c == lat));
      if (c == lat) chk({nm, " rdata"}, rdata[d], exp);
      @(posedge clk); #1;
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    $display("txn %s: dut%0d rd=%b wr=%b addr=%h wdata=%h be=%b rdata=%h",
             nm, d, r, w, a, wdv, b, rdata[d]);
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF};
    tbl[2]  = '{1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 16'hBEEF};
    tbl[3]  = '{1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 16'hBEEF};
    tbl[4]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'hAB34};
    tbl[5]  = '{1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, 16'hAB34};
    tbl[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hABCD};
    tbl[7]  = '{1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'hABCD};
    tbl[8]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hABCD};
    tbl[9]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 16'hABCD};
    tbl[10] = '{1'b1, 1'b0, 16'h0820, 16'h0000, 2'b00, 16'hABCD};
    tbl[11] = '{1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11, 16'hABCD};
    tbl[12] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF};
    tbl[13] = '{1'b0, 1'b1, 16'h0040, 16'hCAFE, 2'b11, 16'hBEEF};
    tbl[14] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'hCAFE};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 16'h0; wd[d] = 16'h0; be[d] = 2'b00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset resp%0d", d),  16'(resp[d]),  16'h0);
      chk($sformatf("reset rdata%0d", d), rdata[d],      16'h0);
      chk($sformatf("reset stall%0d", d), 16'(stall[d]), 16'h0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      txn(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, tbl[i].exp,
          $sformatf("vec%0d", i));

    // Reset in the second WAIT cycle of a write: nothing may commit or pulse.
    wr[0] = 1'b1; addr[0] = 16'h0030; wd[0] = 16'h5555; be[0] = 2'b11;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("abort resp c%0d", c), 16'(resp[0]), 16'h0);
      @(posedge clk); #1;
    end
    rst = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("abort idle resp c%0d", c), 16'(resp[0]), 16'h0);
      chk($sformatf("abort rdata c%0d", c),     rdata[0],     16'h0);
      chk($sformatf("abort stall c%0d", c),     16'(stall[0]), 16'h0);
    end
    @(posedge clk); #1;
    $display("txn abort: write 5555 to 0030 aborted by reset");
    txn(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 16'h1111, "after_abort");

    // Write that deasserts (and scrambles its inputs) during WAIT still commits.
    wr[0] = 1'b1; addr[0] = 16'h0050; wd[0] = 16'h7777; be[0] = 2'b11;
    @(posedge clk); #1;
    wr[0] = 1'b0; addr[0] = 16'h0010; wd[0] = 16'h0000; be[0] = 2'b00;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("drop resp c%0d", c), 16'(resp[0]), 16'(c == 4));
      if (c == 4) chk("drop rdata", rdata[0], 16'h1111);
      @(posedge clk); #1;
    end
    $display("txn drop: write 7777 to 0050 with request dropped in WAIT");
    txn(0, 1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, 16'h7777, "drop_rb");
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, "drop_other");

    // Read whose address changes during WAIT uses the captured address.
    rd[0] = 1'b1; addr[0] = 16'h0040;
    @(posedge clk); #1;
    addr[0] = 16'h0010;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("chg resp c%0d", c), 16'(resp[0]), 16'(c == 4));
      if (c == 4) chk("chg rdata", rdata[0], 16'hCAFE);
      @(posedge clk); #1;
    end
    rd[0] = 1'b0;
    $display("txn chg: read 0040 with address changed in WAIT, rdata=%h", rdata[0]);

    // LATENCY=1 instance; read+write together must act as a write.
    txn(1, 1'b0, 1'b1, 16'h0002, 16'h1357, 2'b11, 16'h0000, "l1_w");
    txn(1, 1'b1, 1'b1, 16'h0002, 16'h2468, 2'b11, 16'h0000, "l1_rw");
    txn(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 16'h2468, "l1_r");
    txn(1, 1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00, 16'h2468, "l1_alias");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
